// File: rtl/div_prog.sv
// Programmable half-integer clock divider: clk / (D/2), D loaded via valid/ready
// and applied only at frame boundaries so clk_out never shows a runt or stretched pulse.
`timescale 1ns/1ps
module div_prog #(
    parameter int unsigned W       = 8,
    parameter int unsigned DEF_DIV = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_valid,
    output logic         div_ready,
    output logic         err,
    output logic         tick,
    output logic         clk_out
);
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] pend_q, pend_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         pend_v_q, pend_v_d;
    logic         err_d, tick_d;
    logic         pos_q, pos_d;
    logic         neg_q, neg_d;
    logic         xfer, frame_start;
    logic [W-1:0] div_new;

    // Target level of clk_out in half-cycle h of a frame of length d; h = 2d is the next frame start.
    function automatic logic level(input logic [W:0] h, input logic [W-1:0] d);
        logic [W:0] dd;
        logic [W:0] ff;
        dd = {1'b0, d};
        ff = {2'b00, d[W-1:1]};
        if (h >= {d, 1'b0})
            return 1'b1;
        return (h < ff) || ((h >= dd) && (h < dd + ff));
    endfunction

    // clk_out = pos_q & neg_q: each flop covers a half-cycle pair, so the AND reproduces
    // the target level exactly as long as every low run is at least two half-cycles.
    function automatic logic even_pair(input logic [W-1:0] c, input logic [W-1:0] d);
        return level({c, 1'b0}, d) | level({c, 1'b1}, d);
    endfunction

    function automatic logic odd_pair(input logic [W-1:0] c, input logic [W-1:0] d);
        return level({c, 1'b1}, d) | level({c, 1'b0} + (W+1)'(2), d);
    endfunction

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        tick_d      = 1'b0;
        pos_d       = 1'b0;
        frame_start = 1'b0;
        xfer        = div_valid && !pend_v_q;
        div_new     = pend_v_q ? pend_q : div_q;

        if (xfer) begin
            if (div_in < W'(3)) begin
                err_d = 1'b1;
            end else begin
                pend_d   = div_in;
                pend_v_d = 1'b1;
            end
        end

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (pend_v_q) begin
                div_d    = pend_q;
                pend_v_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM:  frame_start = 1'b1;
                ST_RUN:  frame_start = (cnt_q == div_q - 1'b1);
                default: state_d = ST_IDLE;
            endcase
            if (frame_start) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                div_d   = div_new;
                tick_d  = 1'b1;
                pos_d   = 1'b1;
                if (pend_v_q)
                    pend_v_d = 1'b0;
            end else if (state_q == ST_RUN) begin
                cnt_d = cnt_q + 1'b1;
                pos_d = even_pair(cnt_d, div_q);
            end
        end
    end

    always_comb begin
        neg_d = 1'b0;
        if (state_q == ST_ARM)
            neg_d = 1'b1;
        else if (state_q == ST_RUN)
            neg_d = odd_pair(cnt_q, div_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            div_q    <= W'(DEF_DIV);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            cnt_q    <= '0;
            err      <= 1'b0;
            tick     <= 1'b0;
            pos_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            cnt_q    <= cnt_d;
            err      <= err_d;
            tick     <= tick_d;
            pos_q    <= pos_d;
        end
    end

    // Fed only from posedge state, which reset forces idle, so it clears on the following negedge.
    always_ff @(negedge clk) begin
        neg_q <= neg_d;
    end

    assign clk_out   = pos_q & neg_q;
    assign div_ready = !pend_v_q;

endmodule

// File: tb/tb_div_prog.sv
// Directed bench for div_prog: measured clk_out periods are compared against
// a queue of spec-derived expectations pushed when each divisor is requested.
`timescale 1ns/1ps
module tb_div_prog;
    localparam int W    = 8;
    localparam int HALF = 20;

    typedef struct {
        int hi;
        int per;
        int negs;
    } per_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div_in;
    logic         div_valid;
    logic         div_ready;
    logic         err;
    logic         tick;
    logic         clk_out;

    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;
    per_t eq[$];
    per_t mq[$];
    time  rise_t = 0;
    time  fall_t = 0;
    int   rise_neg = 0;
    int   fall_neg = 0;
    bit   have_rise = 1'b0;
    bit   on_pos = 1'b0;
    logic co_prev = 1'b0;
    int   c;

    div_prog #(.W(W), .DEF_DIV(13)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_valid(div_valid),
        .div_ready(div_ready),
        .err      (err),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next clk edge and log clk_out edges as complete periods.
    task automatic step_half();
        per_t m;
        @(clk);
        #1;
        on_pos = (clk == 1'b1);
        if (clk_out === 1'b1 && co_prev !== 1'b1) begin
            if (have_rise) begin
                m.hi   = int'(fall_t - rise_t);
                m.per  = int'($time - rise_t);
                m.negs = rise_neg + fall_neg;
                mq.push_back(m);
            end
            rise_t    = $time;
            rise_neg  = on_pos ? 0 : 1;
            have_rise = 1'b1;
        end else if (clk_out !== 1'b1 && co_prev === 1'b1) begin
            fall_t   = $time;
            fall_neg = on_pos ? 0 : 1;
        end
        co_prev = clk_out;
    endtask

    task automatic to_pos();
        step_half();
        if (!on_pos) step_half();
    endtask

    task automatic to_neg();
        step_half();
        if (on_pos) step_half();
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            to_pos();
            cycles++;
        end while (tick !== 1'b1 && cycles < 600);
        if (tick !== 1'b1) chk("tick_timeout", tick, 1);
    endtask

    // Expected periods straight from the waveform definition: high floor(D/2) halves,
    // period D halves; second period of a frame starts at h=D.
    task automatic push_periods(input int d, input int n);
        per_t e;
        int   f;
        for (int i = 0; i < n; i++) begin
            f     = d / 2;
            e.hi  = f * HALF;
            e.per = d * HALF;
            if (i % 2 == 0) e.negs = f % 2;
            else            e.negs = (d % 2) + ((d + f) % 2);
            eq.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        per_t e;
        per_t m;
        int   budget;
        while (eq.size() > 0) begin
            budget = 0;
            while (mq.size() == 0 && budget < 3000) begin
                step_half();
                budget++;
            end
            if (mq.size() == 0) begin
                chk({tag, "_period_timeout"}, mq.size(), 1);
                eq.delete();
            end else begin
                e = eq.pop_front();
                m = mq.pop_front();
                chk({tag, "_high_ns"}, m.hi, e.hi);
                chk({tag, "_period_ns"}, m.per, e.per);
                chk({tag, "_negedge_edges"}, m.negs, e.negs);
            end
        end
    endtask

    task automatic expect_steady(input int d, input int n, input string tag);
        int cy;
        wait_tick(cy);
        mq.delete();
        push_periods(d, n);
        drain(tag);
    endtask

    task automatic reconfig(input int new_d, input int old_d, input int nnew, input string tag);
        int cy;
        wait_tick(cy);
        mq.delete();
        to_neg();
        div_in    = W'(new_d);
        div_valid = 1'b1;
        to_pos();
        to_neg();
        div_valid = 1'b0;
        chk({tag, "_ready_low"}, div_ready, 0);
        push_periods(old_d, 2);
        push_periods(new_d, nnew);
        wait_tick(cy);
        chk({tag, "_apply_cycles"}, cy, old_d - 1);
        chk({tag, "_ready_high"}, div_ready, 1);
        drain(tag);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        div_in    = '0;
        div_valid = 1'b0;

        // reset state
        to_pos(); to_pos(); to_pos();
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", div_ready, 1);

        // first frame one cycle after release
        to_neg();
        rst = 1'b0;
        to_pos();
        chk("pre_start_clk_out", clk_out, 0);
        to_pos();
        chk("first_rise", clk_out, 1);
        chk("first_tick", tick, 1);
        wait_tick(c);
        chk("tick_spacing_d13", c, 13);
        expect_steady(13, 2, "d13");

        // rejected requests
        to_neg();
        div_in = 8'd2; div_valid = 1'b1;
        to_pos();
        chk("err_d2_pulse", err, 1);
        chk("err_d2_ready", div_ready, 1);
        to_neg();
        div_valid = 1'b0;
        to_pos();
        chk("err_d2_width", err, 0);
        to_neg();
        div_in = 8'd0; div_valid = 1'b1;
        to_pos();
        chk("err_d0_pulse", err, 1);
        chk("err_d0_ready", div_ready, 1);
        to_neg();
        div_valid = 1'b0;
        to_pos();
        chk("err_d0_width", err, 0);
        expect_steady(13, 2, "after_err");

        // enable drop during the high phase, then restart
        wait_tick(c);
        to_neg();
        en = 1'b0;
        to_pos();
        chk("en_trunc", clk_out, 0);
        to_pos(); to_pos();
        chk("en_hold", clk_out, 0);
        chk("en_hold_tick", tick, 0);
        to_neg();
        en = 1'b1;
        to_pos();
        chk("en_restart_wait", clk_out, 0);
        to_pos();
        chk("en_restart_rise", clk_out, 1);
        chk("en_restart_tick", tick, 1);
        expect_steady(13, 2, "after_en");

        // reset mid-frame with a pending divisor
        wait_tick(c);
        to_pos(); to_pos();
        to_neg();
        div_in = 8'd8; div_valid = 1'b1;
        to_pos();
        to_neg();
        div_valid = 1'b0;
        chk("pend_ready_low", div_ready, 0);
        rst = 1'b1;
        to_pos();
        chk("midrst_clk_out", clk_out, 0);
        chk("midrst_ready", div_ready, 1);
        to_neg();
        rst = 1'b0;
        to_pos();
        to_pos();
        chk("midrst_restart_tick", tick, 1);
        expect_steady(13, 2, "after_rst");

        // 13 -> 5 mid-frame, with a second request held while not ready
        wait_tick(c);
        to_pos(); to_pos();
        mq.delete();
        to_neg();
        div_in = 8'd5; div_valid = 1'b1;
        to_pos();
        to_neg();
        div_in = 8'd7;
        for (int i = 0; i < 4; i++) begin
            to_pos();
            to_neg();
        end
        chk("busy_ready_low", div_ready, 0);
        div_valid = 1'b0;
        push_periods(13, 2);
        push_periods(5, 3);
        wait_tick(c);
        chk("d5_apply_cycles", c, 6);
        chk("d5_ready_high", div_ready, 1);
        drain("d13_to_d5");

        reconfig(8, 5, 2, "d8");
        reconfig(9, 8, 2, "d9");
        reconfig(255, 9, 3, "d255");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
